// File: rtl/rank_sort_if.sv
// Handshake and result bus for rank_sort: start/rankIn go in, busy/done and
// the sorted value/index vectors come back. Clock and reset stay outside.
interface rank_sort_if #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) ();

  logic                 start;
  logic [N*WIDTH-1:0]   rankIn;
  logic                 busy;
  logic                 done;
  logic [N*WIDTH-1:0]   sortedVal;
  logic [N*IDX_W-1:0]   sortedIdx;

  // Requester side: issues start with a rank vector, observes the result.
  modport master (
    output start,
    output rankIn,
    input  busy,
    input  done,
    input  sortedVal,
    input  sortedIdx
  );

  // Sorter side.
  modport slave (
    input  start,
    input  rankIn,
    output busy,
    output done,
    output sortedVal,
    output sortedIdx
  );

endinterface

// File: rtl/rank_sort.sv
// rank_sort: descending, stable sort of N unsigned rank values with their
// original node indices, using an odd-even transposition network that runs
// one phase per clock. N phases after start the result is published and
// done pulses for one cycle. The published result holds until the next one.
module rank_sort #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  rank_sort_if.slave    bus
);

  localparam int PH_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  logic [PH_W-1:0]              phase;
  logic [N-1:0][WIDTH-1:0]      work_val;
  logic [N-1:0][IDX_W-1:0]      work_idx;
  logic [N-1:0][WIDTH-1:0]      nxt_val;
  logic [N-1:0][IDX_W-1:0]      nxt_idx;
  logic [N-2:0]                 swap;

  logic                         busy;
  logic                         done;
  logic [N-1:0][WIDTH-1:0]      sorted_val;
  logic [N-1:0][IDX_W-1:0]      sorted_idx;

  // Compare stage: pair (g, g+1) is active when its left slot parity matches
  // the phase parity. Swap only on strict less-than so that equal values
  // keep their original (ascending index) order.
  genvar g;
  for (g = 0; g < N - 1; g++) begin : g_cmp
    localparam bit PAR = bit'(g % 2);
    assign swap[g] = (phase[0] == PAR) && (work_val[g] < work_val[g+1]);
  end

  // Exchange stage: each slot takes its right neighbour if its own pair
  // swaps, its left neighbour if the pair to its left swaps, else itself.
  // Active pairs never overlap, so at most one of the two can be set.
  for (g = 0; g < N; g++) begin : g_slot
    if (g == 0) begin : g_first
      assign nxt_val[g] = swap[g] ? work_val[g+1] : work_val[g];
      assign nxt_idx[g] = swap[g] ? work_idx[g+1] : work_idx[g];
    end else if (g == N - 1) begin : g_last
      assign nxt_val[g] = swap[g-1] ? work_val[g-1] : work_val[g];
      assign nxt_idx[g] = swap[g-1] ? work_idx[g-1] : work_idx[g];
    end else begin : g_mid
      assign nxt_val[g] = swap[g]   ? work_val[g+1] :
                          swap[g-1] ? work_val[g-1] : work_val[g];
      assign nxt_idx[g] = swap[g]   ? work_idx[g+1] :
                          swap[g-1] ? work_idx[g-1] : work_idx[g];
    end
  end

  // Control FSM with working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= '0;
      work_val   <= '0;
      work_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sorted_val <= '0;
      sorted_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            // Capture the rank vector once; later rankIn changes are ignored.
            work_val <= bus.rankIn;
            for (int i = 0; i < N; i++) begin
              work_idx[i] <= IDX_W'(i);
            end
            phase <= '0;
            busy  <= 1'b1;
            state <= SORT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SORT: begin
          work_val <= nxt_val;
          work_idx <= nxt_idx;
          if (phase == PH_W'(N - 1)) begin
            // Last phase: publish the network output directly.
            sorted_val <= nxt_val;
            sorted_idx <= nxt_idx;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            phase <= phase + PH_W'(1);
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= SORT;
          end
        end

        DONE: begin
          // start is not sampled here; the next request is taken in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.sortedVal = sorted_val;
  assign bus.sortedIdx = sorted_idx;

endmodule

// File: tb/tb_rank_sort.sv
// Directed bench for rank_sort: reset values, ascending / weighted / all-equal
// / permuted inputs, start re-pulse mid-sort, reset abort mid-sort.
module tb_rank_sort;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  rank_sort_if #(.N(N), .WIDTH(W), .IDX_W(IW)) bus ();

  rank_sort #(.N(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start at the current (negedge) time so it is taken at E0, then
  // watches N+1 cycles. Observations happen at the negedge after edge Ec.
  task automatic run_sort(
    input  logic [N*W-1:0] vals,
    input  int             repulse_at,
    input  logic [N*W-1:0] alt,
    input  int             reset_at,
    output int             done_cyc,
    output int             pulses,
    output int             busy_err,
    output logic [N*W-1:0] mid_val
  );
    logic exp_busy;
    done_cyc = -1;
    pulses   = 0;
    busy_err = 0;
    mid_val  = '0;
    bus.start  = 1'b1;
    bus.rankIn = vals;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        done_cyc = c;
      end
      exp_busy = (c < N) && (reset_at == 0 || c < reset_at);
      if (bus.busy !== exp_busy) busy_err++;
      if (c == N - 1) mid_val = bus.sortedVal;
      if (repulse_at != 0 && c == repulse_at - 1) begin
        bus.start  = 1'b1;
        bus.rankIn = alt;
      end
      if (repulse_at != 0 && c == repulse_at) bus.start = 1'b0;
      if (reset_at != 0 && c == reset_at - 1) reset = 1'b0;
      if (reset_at != 0 && c == reset_at) reset = 1'b1;
    end
  endtask

  task automatic check_run(
    input string          tag,
    input int             done_cyc,
    input int             pulses,
    input int             busy_err,
    input logic [N*W-1:0] mid_val,
    input int             exp_done_cyc,
    input int             exp_pulses,
    input logic [N*W-1:0] exp_mid,
    input logic [N*W-1:0] exp_val,
    input logic [N*IW-1:0] exp_idx
  );
    chk({tag, "_done_cycle"}, 256'(done_cyc), 256'(exp_done_cyc));
    chk({tag, "_done_pulses"}, 256'(pulses), 256'(exp_pulses));
    chk({tag, "_busy_errors"}, 256'(busy_err), 256'(0));
    chk({tag, "_held_val"}, 256'(mid_val), 256'(exp_mid));
    chk({tag, "_sortedVal"}, 256'(bus.sortedVal), 256'(exp_val));
    chk({tag, "_sortedIdx"}, 256'(bus.sortedIdx), 256'(exp_idx));
  endtask

  logic [N*W-1:0]  asc_in, asc_val, wt_in, wt_val, eq_in, perm_in, perm_val;
  logic [N*IW-1:0] asc_idx, wt_idx, eq_idx, perm_idx;
  logic [W-1:0]    pat [4];
  int              wt_ord [16];
  int              dc, pl, be;
  logic [N*W-1:0]  mv;

  initial begin
    pat    = '{16'h5555, 16'h8000, 16'hFFFF, 16'h8000};
    wt_ord = '{2, 6, 10, 14, 1, 3, 5, 7, 9, 11, 13, 15, 0, 4, 8, 12};
    for (int k = 0; k < N; k++) begin
      asc_in[k*W +: W]    = W'(k * 256);
      asc_val[k*W +: W]   = W'((15 - k) * 256);
      asc_idx[k*IW +: IW] = IW'(15 - k);
      wt_in[k*W +: W]     = pat[k % 4];
      wt_val[k*W +: W]    = (k < 4) ? 16'hFFFF : (k < 12) ? 16'h8000 : 16'h5555;
      wt_idx[k*IW +: IW]  = IW'(wt_ord[k]);
      eq_in[k*W +: W]     = 16'h8000;
      eq_idx[k*IW +: IW]  = IW'(k);
      perm_in[k*W +: W]   = W'(((5 * k) % 16) * 4096);
      perm_val[k*W +: W]  = W'((15 - k) * 4096);
      perm_idx[k*IW +: IW] = IW'((13 * (15 - k)) % 16);
    end

    bus.start  = 1'b0;
    bus.rankIn = '0;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 256'(bus.busy), 256'(0));
    chk("reset_done", 256'(bus.done), 256'(0));
    chk("reset_sortedVal", 256'(bus.sortedVal), 256'(0));
    chk("reset_sortedIdx", 256'(bus.sortedIdx), 256'(0));
    reset = 1'b1;

    // First start on the first edge after reset release.
    run_sort(asc_in, 0, '0, 0, dc, pl, be, mv);
    check_run("ascending", dc, pl, be, mv, N, 1, '0, asc_val, asc_idx);

    // Back-to-back from here on: each run starts in the first IDLE cycle.
    run_sort(wt_in, 0, '0, 0, dc, pl, be, mv);
    check_run("weights", dc, pl, be, mv, N, 1, asc_val, wt_val, wt_idx);

    run_sort(eq_in, 0, '0, 0, dc, pl, be, mv);
    check_run("all_equal", dc, pl, be, mv, N, 1, wt_val, eq_in, eq_idx);

    // Start re-pulsed at E5 with different data; rankIn stays changed.
    run_sort(perm_in, 5, asc_in, 0, dc, pl, be, mv);
    check_run("repulse", dc, pl, be, mv, N, 1, eq_in, perm_val, perm_idx);

    // Reset at E8 aborts: no done pulse and all outputs cleared.
    run_sort(asc_in, 0, '0, 8, dc, pl, be, mv);
    check_run("abort", dc, pl, be, mv, -1, 0, '0, '0, '0);

    // A fresh sort after the abort completes normally.
    run_sort(wt_in, 0, '0, 0, dc, pl, be, mv);
    check_run("after_abort", dc, pl, be, mv, N, 1, '0, wt_val, wt_idx);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rank_sort.md
RANK_SORT -- requirements
Module: rank_sort

Interface
REQ-001 SHALL have parameter N, default 16: number of nodes, even, >= 2.
REQ-002 SHALL have parameter WIDTH, default 16: rank value width, unsigned Q0.WIDTH.
REQ-003 SHALL have parameter IDX_W, default 4: index width, 2**IDX_W >= N.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to sort rankIn; sampled only in IDLE.
REQ-007 SHALL have port rankIn  input  N*WIDTH  rank vector from pageRank; slot i is bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-008 SHALL have port busy  output  1  high while a sort is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse when a sort result is published.
REQ-010 SHALL have port sortedVal  output  N*WIDTH  rank values, descending; slot 0 holds the largest.
REQ-011 SHALL have port sortedIdx  output  N*IDX_W  original node index of the matching sortedVal slot.

Function
REQ-012 SHALL implement FSM states IDLE, SORT, DONE.
REQ-013 In IDLE with start=1 at edge E0, SHALL copy rankIn into working value registers, set working index slot i to i, clear the phase counter and enter SORT.
REQ-014 In IDLE with start=0, SHALL hold all registers.
REQ-015 SORT SHALL perform one odd-even transposition phase per clock: even phase count compares pairs (0,1),(2,3),...; odd phase count compares pairs (1,2),(3,4),...,(N-3,N-2).
REQ-016 Each compare SHALL swap value and index together only when left value < right value (strict), making the sort stable: equal values keep ascending original index.
REQ-017 Compares SHALL be unsigned, full WIDTH, with no truncation or saturation.
REQ-018 The phase counter SHALL count 0..N-1; after N phases (edges E1..EN), SHALL enter DONE at edge EN.
REQ-019 At edge EN, SHALL load sortedVal/sortedIdx from the post-phase-(N-1) working registers.
REQ-020 sortedVal/sortedIdx SHALL change only at that load and at reset; they SHALL hold through subsequent sorts until the next load.
REQ-021 done SHALL be high only while in DONE, i.e. for exactly one cycle, between edges EN and EN+1.
REQ-022 DONE SHALL return to IDLE unconditionally at the next edge.
REQ-023 busy SHALL be high exactly while in SORT, between edges E0 and EN.
REQ-024 start SHALL be ignored in SORT and DONE; no queuing.
REQ-025 Back-to-back operation: start asserted in the first IDLE cycle after DONE SHALL be accepted, so the minimum start-to-start spacing is N+2 cycles.
REQ-026 rankIn SHALL be sampled only at E0; later changes SHALL not affect the sort in progress.

Reset
REQ-027 When reset=0 at a rising edge, SHALL enter IDLE and clear busy, done, sortedVal, sortedIdx, working registers and phase counter to 0.
REQ-028 Reset SHALL override start and SHALL abort an in-progress sort (SORT or DONE) with no done pulse.
REQ-029 The first start SHALL be accepted on the first edge after reset returns to 1.

Verification
REQ-030 Reset: hold reset=0 for 2 cycles -> busy=0, done=0, sortedVal=0, sortedIdx=0.
REQ-031 Ascending input: slot i = i*16'h0100, start pulse at E0 -> done high between E16 and E17 only; sortedVal slot k = (15-k)*16'h0100; sortedIdx slot k = 15-k.
REQ-032 Weight pattern: slots repeat 16'h5555, 16'h8000, 16'hFFFF, 16'h8000 -> sortedIdx = 2,6,10,14, 1,3,5,7,9,11,13,15, 0,4,8,12; values FFFF x4, 8000 x8, 5555 x4.
REQ-033 All slots 16'h8000 -> sortedIdx slot k = k (stability); sortedVal all 16'h8000.
REQ-034 Start re-pulsed at E5 with a different rankIn -> ignored; the result matches the E0 data, with one done pulse.
REQ-035 Reset=0 at E8 mid-sort -> no done pulse; outputs are 0; a new start after reset releases completes normally in N+1 cycles.
